// File: rtl/counter_compare_monitor.sv
// counter_compare_monitor
// Samples the behavioural and synthesized 4-bit counter outputs every clock,
// compares them one cycle later and keeps first-failure capture plus
// saturating error and RCO event statistics for scoring a regression run.
module counter_compare_monitor #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic [WIDTH-1:0]     Q,
  input  logic                 RCO,
  input  logic                 LOAD,
  input  logic [WIDTH-1:0]     syn_Q,
  input  logic                 syn_RCO,
  input  logic                 syn_LOAD,
  output logic                 MISMATCH,
  output logic                 FAIL,
  output logic [ERR_CNT_W-1:0] ERR_COUNT,
  output logic [15:0]          FIRST_ERR_CYCLE,
  output logic [WIDTH-1:0]     FIRST_Q,
  output logic [WIDTH-1:0]     FIRST_SYN_Q,
  output logic [7:0]           RCO_COUNT,
  output logic [7:0]           SYN_RCO_COUNT,
  output logic [1:0]           STATE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    FAILED = 2'd3
  } state_t;

  // Settle counter value on which the last ignored sample is evaluated.
  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       settle_cnt, settle_cnt_nxt;

  logic [WIDTH-1:0] s_q_p0, s_syn_q_p0;
  logic             s_rco_p0, s_syn_rco_p0, s_load_p0, s_syn_load_p0;
  logic [15:0]      s_idx_p0;
  logic [15:0]      idx_nxt;

  logic             neq;
  logic             checking;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
  endfunction

  // ---- stage p0: capture both models' outputs and tag with the sample index
  // Register the six model inputs and the index of the sample they belong to.
  always_ff @(posedge clk) begin
    if (RESET) begin
      s_q_p0        <= '0;
      s_syn_q_p0    <= '0;
      s_rco_p0      <= 1'b0;
      s_syn_rco_p0  <= 1'b0;
      s_load_p0     <= 1'b0;
      s_syn_load_p0 <= 1'b0;
      s_idx_p0      <= 16'd0;
      idx_nxt       <= 16'd0;
    end else begin
      s_q_p0        <= Q;
      s_syn_q_p0    <= syn_Q;
      s_rco_p0      <= RCO;
      s_syn_rco_p0  <= syn_RCO;
      s_load_p0     <= LOAD;
      s_syn_load_p0 <= syn_LOAD;
      s_idx_p0      <= idx_nxt;
      idx_nxt       <= sat_inc16(idx_nxt);
    end
  end

  // Case-inequality so unknown values on either model are treated as divergence.
  assign neq      = (s_q_p0 !== s_syn_q_p0) || (s_rco_p0 !== s_syn_rco_p0) ||
                    (s_load_p0 !== s_syn_load_p0);
  assign checking = (state == CHECK) || (state == FAILED);

  // Next-state logic: settle window, then checking until the first divergence.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    case (state)
      IDLE: begin
        settle_cnt_nxt = 4'd0;
        state_nxt      = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
        else settle_cnt_nxt = settle_cnt + 4'd1;
      end
      CHECK:   if (neq) state_nxt = FAILED;
      FAILED:  state_nxt = FAILED;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  // ---- stage p1: registered compare result, first-failure capture and statistics
  // Score the previous sample: pulse, sticky fail, counters and first-failure snapshot.
  always_ff @(posedge clk) begin
    if (RESET) begin
      MISMATCH        <= 1'b0;
      FAIL            <= 1'b0;
      ERR_COUNT       <= '0;
      FIRST_ERR_CYCLE <= 16'd0;
      FIRST_Q         <= '0;
      FIRST_SYN_Q     <= '0;
      RCO_COUNT       <= 8'd0;
      SYN_RCO_COUNT   <= 8'd0;
    end else begin
      MISMATCH <= checking && neq;
      if (checking && neq) begin
        FAIL      <= 1'b1;
        ERR_COUNT <= sat_inc_err(ERR_COUNT);
        if (state == CHECK) begin
          FIRST_ERR_CYCLE <= s_idx_p0;
          FIRST_Q         <= s_q_p0;
          FIRST_SYN_Q     <= s_syn_q_p0;
        end
      end
      if (checking && s_rco_p0)     RCO_COUNT     <= RCO_COUNT + 8'd1;
      if (checking && s_syn_rco_p0) SYN_RCO_COUNT <= SYN_RCO_COUNT + 8'd1;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_counter_compare_monitor.sv
// Scoreboard bench for counter_compare_monitor: the stimulus process pushes the
// expected post-edge outputs from a sample-history reference model; a monitor
// process pops and compares them against the DUT on every falling edge.
module tb_counter_compare_monitor;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 2;
  localparam int ERRW   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             RESET;
  logic [WIDTH-1:0] Q, syn_Q;
  logic             RCO, LOAD, syn_RCO, syn_LOAD;
  logic             MISMATCH, FAIL;
  logic [ERRW-1:0]  ERR_COUNT;
  logic [15:0]      FIRST_ERR_CYCLE;
  logic [WIDTH-1:0] FIRST_Q, FIRST_SYN_Q;
  logic [7:0]       RCO_COUNT, SYN_RCO_COUNT;
  logic [1:0]       STATE;

  counter_compare_monitor #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .ERR_CNT_W(ERRW)) dut (
    .clk(clk), .RESET(RESET), .Q(Q), .RCO(RCO), .LOAD(LOAD),
    .syn_Q(syn_Q), .syn_RCO(syn_RCO), .syn_LOAD(syn_LOAD),
    .MISMATCH(MISMATCH), .FAIL(FAIL), .ERR_COUNT(ERR_COUNT),
    .FIRST_ERR_CYCLE(FIRST_ERR_CYCLE), .FIRST_Q(FIRST_Q), .FIRST_SYN_Q(FIRST_SYN_Q),
    .RCO_COUNT(RCO_COUNT), .SYN_RCO_COUNT(SYN_RCO_COUNT), .STATE(STATE)
  );

  typedef struct {
    logic [3:0] q;
    logic       rco, load;
    logic [3:0] sq;
    logic       srco, sload;
  } samp_t;

  typedef struct {
    logic        mm, fl;
    logic [7:0]  err;
    logic [15:0] fc;
    logic [3:0]  fq, fsq;
    logic [7:0]  rc, src;
    logic [1:0]  st;
  } exp_t;

  exp_t  expq[$];
  samp_t hist[$];
  int    tests = 0;
  int    fails = 0;

  // Reference model state: everything derived from the list of samples since reset.
  int         n_edges;
  int         n_err;
  bit         m_fail;
  bit         m_mm;
  int         m_fc;
  logic [3:0] m_fq, m_fsq;
  int         m_rc, m_src;

  // Sample i is scored on the edge after it is taken, only if i >= SETTLE.
  task automatic model_edge(input bit rst, input samp_t s, output exp_t e);
    samp_t c;
    bit    d;
    if (rst) begin
      hist.delete();
      n_edges = 0; n_err = 0; m_fail = 0; m_mm = 0; m_fc = 0;
      m_fq = 4'd0; m_fsq = 4'd0; m_rc = 0; m_src = 0;
    end else begin
      hist.push_back(s);
      n_edges++;
      m_mm = 0;
      if (n_edges >= 2 && (n_edges - 2) >= SETTLE) begin
        c = hist[n_edges - 2];
        d = (c.q !== c.sq) || (c.rco !== c.srco) || (c.load !== c.sload);
        if (c.rco === 1'b1)  m_rc  = (m_rc + 1) % 256;
        if (c.srco === 1'b1) m_src = (m_src + 1) % 256;
        if (d) begin
          m_mm = 1;
          n_err++;
          if (!m_fail) begin
            m_fail = 1; m_fc = n_edges - 2; m_fq = c.q; m_fsq = c.sq;
          end
        end
      end
    end
    e.mm  = m_mm;
    e.fl  = m_fail;
    e.err = (n_err > 255) ? 8'd255 : 8'(n_err);
    e.fc  = 16'(m_fc);
    e.fq  = m_fq;
    e.fsq = m_fsq;
    e.rc  = 8'(m_rc);
    e.src = 8'(m_src);
    if (n_edges == 0)            e.st = 2'd0;
    else if (m_fail)             e.st = 2'd3;
    else if (n_edges > SETTLE)   e.st = 2'd2;
    else                         e.st = 2'd1;
  endtask

  task automatic cyc(input bit rst, input logic [3:0] q, input logic rco, input logic load,
                     input logic [3:0] sq, input logic srco, input logic sload);
    samp_t s;
    exp_t  e;
    @(negedge clk);
    RESET = rst; Q = q; RCO = rco; LOAD = load; syn_Q = sq; syn_RCO = srco; syn_LOAD = sload;
    s.q = q; s.rco = rco; s.load = load; s.sq = sq; s.srco = srco; s.sload = sload;
    model_edge(rst, s, e);
    @(posedge clk);
    expq.push_back(e);
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) cyc(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared on the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("MISMATCH",        16'(MISMATCH),      16'(e.mm));
        chk("FAIL_flag",       16'(FAIL),          16'(e.fl));
        chk("ERR_COUNT",       16'(ERR_COUNT),     16'(e.err));
        chk("FIRST_ERR_CYCLE", FIRST_ERR_CYCLE,    e.fc);
        chk("FIRST_Q",         16'(FIRST_Q),       16'(e.fq));
        chk("FIRST_SYN_Q",     16'(FIRST_SYN_Q),   16'(e.fsq));
        chk("RCO_COUNT",       16'(RCO_COUNT),     16'(e.rc));
        chk("SYN_RCO_COUNT",   16'(SYN_RCO_COUNT), 16'(e.src));
        chk("STATE",           16'(STATE),         16'(e.st));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d checks, expected completion", tests);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [3:0] q;
    logic       rco, ld;
    RESET = 1'b1; Q = '0; RCO = 0; LOAD = 0; syn_Q = '0; syn_RCO = 0; syn_LOAD = 0;

    // Identical free-running counters.
    do_reset(3);
    for (int i = 0; i < 50; i++) begin
      q = 4'(i); rco = (q == 4'hF);
      cyc(1'b0, q, rco, 1'b0, q, rco, 1'b0);
    end

    // Single syn_Q divergence at sample 20 (Q=4, syn_Q=5).
    do_reset(1);
    for (int i = 0; i < 30; i++) begin
      q = 4'(i); rco = (q == 4'hF);
      cyc(1'b0, q, rco, 1'b0, (i == 20) ? 4'h5 : q, rco, 1'b0);
    end

    // syn_LOAD divergence inside the settle window, then a checked one at 10.
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      q = 4'(i); rco = (q == 4'hF);
      cyc(1'b0, q, rco, 1'b0, q, rco, (i < 2) || (i == 10));
    end

    // Continuous syn_RCO divergence drives ERR_COUNT into saturation.
    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      q = 4'(i); rco = (q == 4'hF);
      cyc(1'b0, q, rco, 1'b0, q, ~rco, 1'b0);
    end

    // One-cycle reset while FAILED, then identical stimulus.
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      q = 4'(i); rco = (q == 4'hF);
      cyc(1'b0, q, rco, 1'b0, q, rco, 1'b0);
    end

    // Unknown syn_RCO for one checked sample.
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      q = 4'(i);
      if (i == 5) cyc(1'b0, q, 1'b1, 1'b0, q, 1'bx, 1'b0);
      else        cyc(1'b0, q, 1'b0, 1'b0, q, 1'b0, 1'b0);
    end

    // Randomized: sparse divergences on any field and occasional resets.
    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      q   = 4'($urandom_range(0, 15));
      rco = ($urandom_range(0, 3) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      cyc(($urandom_range(0, 99) == 0),
          q, rco, ld,
          ($urandom_range(0, 29) == 0) ? q ^ 4'(1 << $urandom_range(0, 3)) : q,
          ($urandom_range(0, 29) == 0) ? ~rco : rco,
          ($urandom_range(0, 29) == 0) ? ~ld : ld);
    end

    repeat (3) @(posedge clk);
    #1;
    if (expq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_compare_monitor.md
Name: counter_compare_monitor

Overview:
- Downstream consumer of the 4-bit counter pair: the behavioural model and the synthesized structural netlist.
- Samples both models' Q, RCO and LOAD every clock and flags any divergence.
- Captures the first failing cycle and keeps saturating error and event statistics.
- Sits in the counters bench beside the driver, so regressions across timing/path variants can be scored without waveform inspection.

Parameters:
- WIDTH, 4: counter data width (Q, syn_Q, FIRST_Q, FIRST_SYN_Q).
- SETTLE_CYCLES, 2: sampled cycles after reset release during which compares are ignored. Legal range 0..15.
- ERR_CNT_W, 8: width of ERR_COUNT.

Ports:
- clk  in  1  bench clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- Q  in  WIDTH  behavioural counter value.
- RCO  in  1  behavioural ripple-carry-out.
- LOAD  in  1  behavioural load indication.
- syn_Q  in  WIDTH  synthesized counter value.
- syn_RCO  in  1  synthesized ripple-carry-out.
- syn_LOAD  in  1  synthesized load indication.
- MISMATCH  out  1  one-cycle pulse per mismatching sample.
- FAIL  out  1  sticky: at least one mismatch since reset.
- ERR_COUNT  out  ERR_CNT_W  saturating mismatch count.
- FIRST_ERR_CYCLE  out  16  sample index of the first mismatch.
- FIRST_Q  out  WIDTH  Q at the first mismatch.
- FIRST_SYN_Q  out  WIDTH  syn_Q at the first mismatch.
- RCO_COUNT  out  8  behavioural RCO-high samples (wraps).
- SYN_RCO_COUNT  out  8  synthesized RCO-high samples (wraps).
- STATE  out  2  FSM state: 0 IDLE, 1 SETTLE, 2 CHECK, 3 FAILED.

Behaviour:
- Reset: while RESET=1 at a rising edge, every output and internal register goes to 0 and STATE=IDLE. This applies mid-operation in any state and takes effect at that edge.
- Sampling:
  - Every edge with RESET=0 registers all six model inputs into sample regs (s_*).
  - An internal 16-bit sample index increments each such edge, saturating at 16'hFFFF.
  - The index is 0 for the first sample after reset release.
- Compare:
  - neq = (s_Q vs s_syn_Q) OR (s_RCO vs s_syn_RCO) OR (s_LOAD vs s_syn_LOAD).
  - In simulation the compare is 4-state case-inequality, so X/Z on either side counts as a mismatch.
- Latency:
  - Inputs captured at edge E0 are compared and the result is registered at E1.
  - MISMATCH is high from E1 to E2. A fixed 1-cycle compare latency follows the sample edge.
- FSM transitions (evaluated at each edge with RESET=0):
  - IDLE -> SETTLE on the first edge; goes directly to CHECK if SETTLE_CYCLES=0.
  - SETTLE counts samples. After SETTLE_CYCLES samples it moves to CHECK. neq is ignored while in SETTLE (no MISMATCH, no counts).
  - CHECK: neq=1 -> FAILED. Same edge: MISMATCH=1, FAIL=1, ERR_COUNT+1, FIRST_ERR_CYCLE=index of the offending sample, FIRST_Q=s_Q, FIRST_SYN_Q=s_syn_Q.
  - FAILED is terminal until RESET.
    - MISMATCH keeps pulsing and ERR_COUNT keeps incrementing on every neq.
    - FIRST_* stay frozen.
- ERR_COUNT saturates at all-ones; it never wraps.
- RCO counters:
  - RCO_COUNT increments when s_RCO=1, and SYN_RCO_COUNT when s_syn_RCO=1.
  - Both count only in CHECK/FAILED and wrap modulo 256.
- Simultaneous events: RESET=1 wins over any compare result on the same edge. A mismatch on the exact sample that ends SETTLE is ignored; the first checked sample is the next one.
- No combinational path from inputs to outputs; every output is registered.

Test Plan:
- Identical stimulus, 50 cycles, counter free-running mode, SETTLE_CYCLES=2 -> STATE=CHECK from sample 2. MISMATCH never high, FAIL=0, ERR_COUNT=0, RCO_COUNT==SYN_RCO_COUNT (3 wraps -> 3).
- Force syn_Q=4'h5 while Q=4'h4 at sample 20 only -> MISMATCH high one cycle after the sample edge. Then FAIL=1, STATE=FAILED, ERR_COUNT=1, FIRST_ERR_CYCLE=20, FIRST_Q=4'h4, FIRST_SYN_Q=4'h5.
- Mismatch on syn_LOAD at samples 0 and 1 (inside SETTLE) -> no MISMATCH, FAIL=0, ERR_COUNT=0. A later mismatch at sample 10 sets FIRST_ERR_CYCLE=10.
- Continuous syn_RCO mismatch for 300 samples, ERR_CNT_W=8 -> ERR_COUNT=255 and held. FIRST_ERR_CYCLE stays at the first index.
- RESET pulsed for one cycle while in FAILED -> next cycle all outputs 0, STATE=IDLE. After reset release, identical stimulus gives FAIL=0.
- syn_RCO driven X for one sample in CHECK -> MISMATCH=1, FAIL=1, ERR_COUNT=1.
